// File: rtl/serial_pkg.sv
// Shared definitions for the serial host port: default widths and the receiver FSM encoding,
// used by serial_in, serial_out and the host-side bench driver.
package serial_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int ADDR_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HEADER = 2'd1;
    localparam state_t ST_DATA   = 2'd2;

    function automatic logic is_active(input state_t s);
        return (s == ST_HEADER) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous input.
// Edge outputs stay quiet until the chain has refilled with real samples after reset.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;
    logic [STAGES:0]   r_fill;
    logic              w_settled;

    // Synchronizer chain, previous-value flop and post-reset fill tracker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
            r_fill  <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
            r_fill  <= {r_fill[STAGES-1:0], 1'b1};
        end
    end

    // A reset value in the chain must never look like a real edge once real samples arrive.
    assign w_settled = r_fill[STAGES];
    assign o_sync    = r_chain[STAGES-1];
    assign o_rise    = w_settled &  r_chain[STAGES-1] & ~r_prev;
    assign o_fall    = w_settled & ~r_chain[STAGES-1] &  r_prev;

endmodule

// File: rtl/serial_in.sv
// SPI-style slave receiver: oversamples sclk/mosi/cs_n, assembles MSB-first words and issues
// single-cycle write strobes with an auto-incrementing address (optional header word = start address).
module serial_in
    import serial_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HEADER_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              err_partial,
    output logic              busy
);

    localparam int         CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic              w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic              w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic              w_cs_sync, w_cs_rise, w_cs_fall;
    logic [4:0]        w_unused_bits;
    logic [DATA_W-1:0] w_word;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_frame_done;
    logic              r_err_partial;
    logic              r_busy;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(cs_n),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_unused_bits = {w_sclk_sync, w_sclk_fall, w_mosi_rise, w_mosi_fall, w_cs_sync};
    assign w_word        = {r_shift[DATA_W-2:0], w_mosi_sync};

    // Frame FSM, shift register, bit counter and registered write/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_done  <= 1'b0;
            r_err_partial <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_partial <= 1'b0;
            // Address advances in the cycle after each strobe, so the strobe carries the current one.
            if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (r_state == ST_IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= (HEADER_EN != 0) ? ST_HEADER : ST_DATA;
                    r_busy    <= 1'b1;
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    if (HEADER_EN == 0) begin
                        r_wr_addr <= '0;
                    end
                end
            end else if (is_active(r_state)) begin
                // Frame end wins over a coincident sclk edge; that bit is dropped.
                if (w_cs_rise) begin
                    r_state       <= ST_IDLE;
                    r_busy        <= 1'b0;
                    r_frame_done  <= 1'b1;
                    r_err_partial <= (r_bit_cnt != '0);
                end else if (w_sclk_rise) begin
                    r_shift <= w_word;
                    if (r_bit_cnt == CNT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_state == ST_HEADER) begin
                            r_wr_addr <= w_word[ADDR_W-1:0];
                            r_state   <= ST_DATA;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_word;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_done  = r_frame_done;
    assign err_partial = r_err_partial;
    assign busy        = r_busy;

endmodule
